// File: rtl/jelly2_axi4s_img_src.sv
// AXI4-Stream video slave feeding the image-pipeline source bus.
// It checks frame geometry, resyncs on a misplaced SOF, flushes blank lines and counts errors.
module jelly2_axi4s_img_src #(
    parameter  int TUSER_WIDTH     = 1,
    parameter  int COMPONENTS      = 3,
    parameter  int COMPONENT_WIDTH = 8,
    parameter  int IMG_X_WIDTH     = 10,
    parameter  int IMG_Y_WIDTH     = 9,
    parameter  int BLANK_Y_WIDTH   = 7,
    localparam int DATA_WIDTH      = COMPONENTS * COMPONENT_WIDTH,
    localparam int USER_WIDTH      = (TUSER_WIDTH > 1) ? TUSER_WIDTH - 1 : 1
) (
    input  logic                     aresetn,
    input  logic                     aclk,
    input  logic                     aclken,
    input  logic                     img_cke,

    input  logic [IMG_X_WIDTH-1:0]   param_img_width,
    input  logic [IMG_Y_WIDTH-1:0]   param_img_height,
    input  logic [BLANK_Y_WIDTH-1:0] param_blank_height,

    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [DATA_WIDTH-1:0]    s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,

    output logic                     m_img_row_first,
    output logic                     m_img_row_last,
    output logic                     m_img_col_first,
    output logic                     m_img_col_last,
    output logic                     m_img_de,
    output logic [USER_WIDTH-1:0]    m_img_user,
    output logic [DATA_WIDTH-1:0]    m_img_data,
    output logic                     m_img_valid,

    output logic                     err_frame,
    output logic [15:0]              err_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_BLANK
    } state_t;

    logic                  cke;
    logic                  sof;
    logic [USER_WIDTH-1:0] s_user;

    assign cke = aclken & img_cke;
    assign sof = s_axi4s_tuser[0];

    generate
        if (TUSER_WIDTH > 1) begin : g_user
            assign s_user = s_axi4s_tuser[TUSER_WIDTH-1:1];
        end else begin : g_no_user
            assign s_user = '0;
        end
    endgenerate

    state_t                   state_q, state_d;
    logic [IMG_X_WIDTH-1:0]   w_q, w_d;
    logic [IMG_Y_WIDTH-1:0]   h_q, h_d;
    logic [BLANK_Y_WIDTH-1:0] bh_q, bh_d;
    logic [IMG_X_WIDTH-1:0]   x_q, x_d;
    logic [IMG_Y_WIDTH-1:0]   y_q, y_d;
    logic [IMG_X_WIDTH-1:0]   bx_q, bx_d;
    logic [BLANK_Y_WIDTH-1:0] by_q, by_d;

    logic                     row_first_q, row_first_d;
    logic                     row_last_q, row_last_d;
    logic                     col_first_q, col_first_d;
    logic                     col_last_q, col_last_d;
    logic                     de_q, de_d;
    logic                     valid_q, valid_d;
    logic [USER_WIDTH-1:0]    user_q, user_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     err_frame_q, err_frame_d;
    logic [15:0]              err_count_q, err_count_d;

    // Geometry and position of the beat being considered this cycle.
    logic                     accept;
    logic                     sof_err;
    logic                     tlast_err;
    logic [IMG_X_WIDTH-1:0]   cw, cx;
    logic [IMG_Y_WIDTH-1:0]   ch, cy;
    logic [BLANK_Y_WIDTH-1:0] cbh;
    logic                     col_last_c;
    logic                     row_last_c;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        h_d         = h_q;
        bh_d        = bh_q;
        x_d         = x_q;
        y_d         = y_q;
        bx_d        = bx_q;
        by_d        = by_q;
        row_first_d = row_first_q;
        row_last_d  = row_last_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        de_d        = de_q;
        valid_d     = valid_q;
        user_d      = user_q;
        data_d      = data_q;
        err_count_d = err_count_q;
        s_axi4s_tready = 1'b0;
        accept      = 1'b0;
        sof_err     = 1'b0;
        tlast_err   = 1'b0;
        cw          = w_q;
        ch          = h_q;
        cbh         = bh_q;
        cx          = x_q;
        cy          = y_q;

        case (state_q)
            ST_IDLE: begin
                s_axi4s_tready = cke & aresetn;
                cw     = param_img_width;
                ch     = param_img_height;
                cbh    = param_blank_height;
                cx     = '0;
                cy     = '0;
                accept = cke & s_axi4s_tvalid & sof
                       & (param_img_width != '0) & (param_img_height != '0);
            end
            ST_ACTIVE: begin
                s_axi4s_tready = cke & aresetn & ~(s_axi4s_tvalid & sof);
                accept  = cke & s_axi4s_tvalid & ~sof;
                sof_err = cke & s_axi4s_tvalid & sof;
            end
            default: ;
        endcase

        col_last_c = (cx == cw - 1'b1);
        row_last_c = (cy == ch - 1'b1);

        if (cke) begin
            valid_d     = 1'b0;
            de_d        = 1'b0;
            row_first_d = 1'b0;
            row_last_d  = 1'b0;
            col_first_d = 1'b0;
            col_last_d  = 1'b0;

            if (accept) begin
                valid_d     = 1'b1;
                de_d        = 1'b1;
                data_d      = s_axi4s_tdata;
                user_d      = s_user;
                col_first_d = (cx == '0);
                col_last_d  = col_last_c;
                row_first_d = (cy == '0);
                row_last_d  = row_last_c;
                w_d         = cw;
                h_d         = ch;
                bh_d        = cbh;
                tlast_err   = (s_axi4s_tlast != col_last_c);
                if (col_last_c) begin
                    x_d = '0;
                    if (row_last_c) begin
                        y_d     = '0;
                        bx_d    = '0;
                        by_d    = '0;
                        state_d = (cbh != '0) ? ST_BLANK : ST_IDLE;
                    end else begin
                        y_d     = cy + 1'b1;
                        state_d = ST_ACTIVE;
                    end
                end else begin
                    x_d     = cx + 1'b1;
                    y_d     = cy;
                    state_d = ST_ACTIVE;
                end
            end else if (sof_err) begin
                // The offending SOF beat stays on the bus and restarts the frame from IDLE.
                x_d     = '0;
                y_d     = '0;
                bx_d    = '0;
                by_d    = '0;
                state_d = (bh_q != '0) ? ST_BLANK : ST_IDLE;
            end else if (state_q == ST_BLANK) begin
                valid_d = 1'b1;
                if (bx_q == w_q - 1'b1) begin
                    bx_d = '0;
                    if (by_q == bh_q - 1'b1) begin
                        by_d    = '0;
                        state_d = ST_IDLE;
                    end else begin
                        by_d = by_q + 1'b1;
                    end
                end else begin
                    bx_d = bx_q + 1'b1;
                end
            end
        end

        err_frame_d = sof_err | tlast_err;
        if (err_frame_d && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            w_q         <= '0;
            h_q         <= '0;
            bh_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            row_first_q <= 1'b0;
            row_last_q  <= 1'b0;
            col_first_q <= 1'b0;
            col_last_q  <= 1'b0;
            de_q        <= 1'b0;
            valid_q     <= 1'b0;
            user_q      <= '0;
            data_q      <= '0;
            err_frame_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            h_q         <= h_d;
            bh_q        <= bh_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            row_first_q <= row_first_d;
            row_last_q  <= row_last_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
            de_q        <= de_d;
            valid_q     <= valid_d;
            user_q      <= user_d;
            data_q      <= data_d;
            err_frame_q <= err_frame_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_img_row_first = row_first_q;
    assign m_img_row_last  = row_last_q;
    assign m_img_col_first = col_first_q;
    assign m_img_col_last  = col_last_q;
    assign m_img_de        = de_q;
    assign m_img_user      = user_q;
    assign m_img_data      = data_q;
    assign m_img_valid     = valid_q;
    assign err_frame       = err_frame_q;
    assign err_count       = err_count_q;

endmodule

// File: tb/tb_jelly2_axi4s_img_src.sv
// Self-checking bench for jelly2_axi4s_img_src: random beats and clock enables
// compared against a frame-level model of the expected output sequence.
module tb_jelly2_axi4s_img_src;

    localparam int TUSER_WIDTH     = 3;
    localparam int COMPONENTS      = 3;
    localparam int COMPONENT_WIDTH = 8;
    localparam int IMG_X_WIDTH     = 10;
    localparam int IMG_Y_WIDTH     = 9;
    localparam int BLANK_Y_WIDTH   = 7;
    localparam int DW              = COMPONENTS * COMPONENT_WIDTH;
    localparam int UW              = TUSER_WIDTH - 1;

    logic                     aresetn;
    logic                     aclk;
    logic                     aclken;
    logic                     img_cke;
    logic [IMG_X_WIDTH-1:0]   param_img_width;
    logic [IMG_Y_WIDTH-1:0]   param_img_height;
    logic [BLANK_Y_WIDTH-1:0] param_blank_height;
    logic [TUSER_WIDTH-1:0]   s_axi4s_tuser;
    logic                     s_axi4s_tlast;
    logic [DW-1:0]            s_axi4s_tdata;
    logic                     s_axi4s_tvalid;
    logic                     s_axi4s_tready;
    logic                     m_img_row_first;
    logic                     m_img_row_last;
    logic                     m_img_col_first;
    logic                     m_img_col_last;
    logic                     m_img_de;
    logic [UW-1:0]            m_img_user;
    logic [DW-1:0]            m_img_data;
    logic                     m_img_valid;
    logic                     err_frame;
    logic [15:0]              err_count;

    jelly2_axi4s_img_src #(
        .TUSER_WIDTH     (TUSER_WIDTH),
        .COMPONENTS      (COMPONENTS),
        .COMPONENT_WIDTH (COMPONENT_WIDTH),
        .IMG_X_WIDTH     (IMG_X_WIDTH),
        .IMG_Y_WIDTH     (IMG_Y_WIDTH),
        .BLANK_Y_WIDTH   (BLANK_Y_WIDTH)
    ) dut (
        .aresetn            (aresetn),
        .aclk               (aclk),
        .aclken             (aclken),
        .img_cke            (img_cke),
        .param_img_width    (param_img_width),
        .param_img_height   (param_img_height),
        .param_blank_height (param_blank_height),
        .s_axi4s_tuser      (s_axi4s_tuser),
        .s_axi4s_tlast      (s_axi4s_tlast),
        .s_axi4s_tdata      (s_axi4s_tdata),
        .s_axi4s_tvalid     (s_axi4s_tvalid),
        .s_axi4s_tready     (s_axi4s_tready),
        .m_img_row_first    (m_img_row_first),
        .m_img_row_last     (m_img_row_last),
        .m_img_col_first    (m_img_col_first),
        .m_img_col_last     (m_img_col_last),
        .m_img_de           (m_img_de),
        .m_img_user         (m_img_user),
        .m_img_data         (m_img_data),
        .m_img_valid        (m_img_valid),
        .err_frame          (err_frame),
        .err_count          (err_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic          valid;
        logic          de;
        logic          rf;
        logic          rl;
        logic          cf;
        logic          cl;
        logic [UW-1:0] user;
        logic [DW-1:0] data;
    } out_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          sof;
        logic          last;
        logic          emit;
    } beat_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_pulses = 0;
    bit   rand_mode  = 1'b0;
    out_t exp_q[$];
    beat_t beat_q[$];
    out_t prev_out;

    function automatic out_t cur_out();
        out_t o;
        o.valid = m_img_valid;
        o.de    = m_img_de;
        o.rf    = m_img_row_first;
        o.rl    = m_img_row_last;
        o.cf    = m_img_col_first;
        o.cl    = m_img_col_last;
        o.user  = m_img_user;
        o.data  = m_img_data;
        return o;
    endfunction

    // Model: a frame is a raster of w*h pixels, optionally followed by bh*w blank cycles holding the last pixel.
    task automatic add_frame(input int w, input int h, input int bh, input int npix, input bit blank_after);
        beat_t b;
        out_t  e;
        out_t  last_e;
        int    k;
        k = 0;
        last_e = '0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                if (k < npix) begin
                    b.data = DW'($urandom);
                    b.user = UW'($urandom);
                    b.sof  = (k == 0);
                    b.last = (x == w - 1);
                    b.emit = 1'b1;
                    beat_q.push_back(b);
                    e.valid = 1'b1;
                    e.de    = 1'b1;
                    e.rf    = (y == 0);
                    e.rl    = (y == h - 1);
                    e.cf    = (x == 0);
                    e.cl    = (x == w - 1);
                    e.user  = b.user;
                    e.data  = b.data;
                    exp_q.push_back(e);
                    last_e = e;
                end
                k++;
            end
        end
        if (blank_after) begin
            for (int i = 0; i < bh * w; i++) begin
                e = last_e;
                e.de = 1'b0;
                e.rf = 1'b0;
                e.rl = 1'b0;
                e.cf = 1'b0;
                e.cl = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive_next(input logic fired);
        logic hold;
        hold = s_axi4s_tvalid && !fired;
        if (rand_mode) begin
            aclken  = ($urandom_range(0, 4) != 0);
            img_cke = ($urandom_range(0, 4) != 0);
        end else begin
            aclken  = 1'b1;
            img_cke = 1'b1;
        end
        if (beat_q.size() > 0 && (hold || !rand_mode || $urandom_range(0, 99) >= 20)) begin
            s_axi4s_tvalid = 1'b1;
            s_axi4s_tdata  = beat_q[0].data;
            s_axi4s_tuser  = {beat_q[0].user, beat_q[0].sof};
            s_axi4s_tlast  = beat_q[0].last;
        end else begin
            s_axi4s_tvalid = 1'b0;
            s_axi4s_tdata  = DW'($urandom);
            s_axi4s_tuser  = TUSER_WIDTH'($urandom);
            s_axi4s_tlast  = 1'b0;
        end
    endtask

    // One aclk cycle: sample handshake before the edge, outputs 1 time unit after it.
    task automatic step();
        logic  fire;
        logic  cke_now;
        out_t  o;
        out_t  e;
        beat_t b;
        @(negedge aclk);
        fire    = s_axi4s_tvalid & s_axi4s_tready;
        cke_now = aclken & img_cke;
        @(posedge aclk);
        #1;
        o = cur_out();
        if (err_frame === 1'b1) err_pulses++;
        if (!cke_now) begin
            n_checks++;
            if (o !== prev_out) begin
                n_fail++;
                $display("FAIL freeze_on_cke0: got %h required %h", o, prev_out);
            end
        end else if (o.valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_output: got %h required no valid output", o);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL output_seq: got %h required %h", o, e);
                end
            end
        end
        if (fire && beat_q.size() > 0) begin
            b = beat_q.pop_front();
            if (b.emit) begin
                n_checks++;
                if (!(o.valid === 1'b1 && o.de === 1'b1 && o.data === b.data)) begin
                    n_fail++;
                    $display("FAIL latency: got valid=%b de=%b data=%h required valid=1 de=1 data=%h",
                             o.valid, o.de, o.data, b.data);
                end
            end
        end
        prev_out = o;
        drive_next(fire);
    endtask

    task automatic run(input int budget, input bit mid_change, input int tail);
        int n;
        n = 0;
        while ((beat_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
            if (mid_change && beat_q.size() == 6) begin
                param_img_width    = 10'd7;
                param_img_height   = 9'd5;
                param_blank_height = 7'd0;
            end
        end
        n_checks++;
        if (beat_q.size() != 0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL timeout: got %0d beats and %0d outputs pending required 0 and 0",
                     beat_q.size(), exp_q.size());
            beat_q.delete();
            exp_q.delete();
        end
        repeat (tail) step();
    endtask

    task automatic set_geom(input int w, input int h, input int bh);
        param_img_width    = IMG_X_WIDTH'(w);
        param_img_height   = IMG_Y_WIDTH'(h);
        param_blank_height = BLANK_Y_WIDTH'(bh);
    endtask

    task automatic do_reset();
        aresetn        = 1'b0;
        aclken         = 1'b1;
        img_cke        = 1'b1;
        s_axi4s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        beat_q.delete();
        exp_q.delete();
        err_pulses = 0;
        prev_out   = cur_out();
    endtask

    task automatic check_errors(input string name, input int exp_err);
        n_checks++;
        if (err_pulses != exp_err) begin
            n_fail++;
            $display("FAIL %s_err_pulses: got %0d required %0d", name, err_pulses, exp_err);
        end
        n_checks++;
        if (err_count !== 16'(exp_err)) begin
            n_fail++;
            $display("FAIL %s_err_count: got %0d required %0d", name, err_count, exp_err);
        end
    endtask

    task automatic check_idle_ready(input string name);
        rand_mode      = 1'b0;
        aclken         = 1'b1;
        img_cke        = 1'b1;
        s_axi4s_tvalid = 1'b0;
        @(negedge aclk);
        n_checks++;
        if (s_axi4s_tready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_tready: got %b required 1", name, s_axi4s_tready);
        end
        @(posedge aclk);
        #1;
        prev_out = cur_out();
    endtask

    task automatic check_all_zero(input string name);
        out_t o;
        o = cur_out();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL %s_outputs: got %h required 0", name, o);
        end
        n_checks++;
        if (s_axi4s_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_tready: got %b required 0", name, s_axi4s_tready);
        end
        n_checks++;
        if (err_frame !== 1'b0 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL %s_err: got err_frame=%b err_count=%0d required 0 and 0", name, err_frame, err_count);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b1;
        aclken  = 1'b1;
        img_cke = 1'b1;
        set_geom(4, 3, 2);
        s_axi4s_tvalid = 1'b1;
        s_axi4s_tuser  = 3'b001;
        s_axi4s_tlast  = 1'b0;
        s_axi4s_tdata  = 24'hABCDEF;
        #1 aresetn = 1'b0;
        #12;
        check_all_zero("reset");
        do_reset();
    endtask

    task automatic test_basic_frame();
        set_geom(4, 3, 2);
        do_reset();
        rand_mode = 1'b0;
        add_frame(4, 3, 2, 12, 1'b1);
        run(200, 1'b0, 6);
        check_errors("basic", 0);
        check_idle_ready("basic");
    endtask

    task automatic test_random_cke();
        set_geom(4, 3, 2);
        do_reset();
        rand_mode = 1'b1;
        add_frame(4, 3, 2, 12, 1'b1);
        add_frame(4, 3, 2, 12, 1'b1);
        run(3000, 1'b0, 20);
        check_errors("random_cke", 0);
        check_idle_ready("random_cke");
    endtask

    task automatic test_sof_resync();
        set_geom(4, 3, 2);
        do_reset();
        rand_mode = 1'b0;
        add_frame(4, 3, 2, 6, 1'b1);
        add_frame(4, 3, 2, 12, 1'b1);
        run(300, 1'b0, 6);
        check_errors("sof_resync", 1);
    endtask

    task automatic test_tlast_errors();
        beat_t b;
        set_geom(4, 3, 2);
        do_reset();
        rand_mode = 1'b0;
        add_frame(4, 3, 2, 12, 1'b1);
        b = beat_q[1];
        b.last = 1'b1;
        beat_q[1] = b;
        b = beat_q[7];
        b.last = 1'b0;
        beat_q[7] = b;
        run(300, 1'b1, 6);
        check_errors("tlast", 2);
    endtask

    task automatic test_single_pixel();
        set_geom(1, 1, 0);
        do_reset();
        rand_mode = 1'b0;
        add_frame(1, 1, 0, 1, 1'b1);
        run(100, 1'b0, 6);
        check_errors("single_pixel", 0);
        check_idle_ready("single_pixel");
    endtask

    task automatic test_reset_mid_frame();
        beat_t b;
        set_geom(4, 3, 2);
        do_reset();
        rand_mode = 1'b0;
        add_frame(4, 3, 2, 5, 1'b0);
        run(100, 1'b0, 0);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge aclk);
        #1 aresetn = 1'b1;
        beat_q.delete();
        exp_q.delete();
        err_pulses     = 0;
        s_axi4s_tvalid = 1'b0;
        prev_out       = cur_out();
        for (int i = 0; i < 5; i++) begin
            b.data = DW'($urandom);
            b.user = UW'($urandom);
            b.sof  = 1'b0;
            b.last = (i == 3);
            b.emit = 1'b0;
            beat_q.push_back(b);
        end
        add_frame(4, 3, 2, 12, 1'b1);
        run(300, 1'b0, 6);
        check_errors("mid_reset", 0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_random_cke();
        test_sof_resync();
        test_tlast_errors();
        test_single_pixel();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
